// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if: request, breakpoint and status signals between the debug panel and cycle_sequencer
interface cycle_sequencer_if #(
  parameter int PC_W = 8,
  parameter int CNT_W = 16
);
  logic run;
  logic stop;
  logic step;
  logic brk_en;
  logic [PC_W-1:0] brk_addr;
  logic [PC_W-1:0] pc;
  logic haltn;
  logic [1:0] state;
  logic [2:0] phase;
  logic cyc_end;
  logic brk_hit;
  logic [CNT_W-1:0] cyc_cnt;
  modport master (
    output run, stop, step, brk_en, brk_addr, pc,
    input haltn, state, phase, cyc_end, brk_hit, cyc_cnt
  );
  modport slave (
    input run, stop, step, brk_en, brk_addr, pc,
    output haltn, state, phase, cyc_end, brk_hit, cyc_cnt
  );
endinterface

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: run/halt/step/breakpoint control of the pulse timer gate, changing only on machine-cycle boundaries
module cycle_sequencer #(
  parameter int PC_W = 8,
  parameter int CNT_W = 16
) (
  input logic INCLK,
  input logic RST,
  cycle_sequencer_if.slave bus
);
  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_BRK = 2'b11;
  logic [2:0] phase;
  logic [1:0] state, state_n;
  logic haltn, brk_hit, brk_hit_n, skip, skip_n;
  logic p_run, p_stop, p_step;
  logic run_q, stop_q, step_q, bnd, match;
  logic [CNT_W-1:0] cnt;
  assign bnd = phase == 3'd5;
  // requests seen at any edge of the cycle count, including the boundary edge itself
  assign run_q = p_run | bus.run;
  assign stop_q = p_stop | bus.stop;
  assign step_q = p_step | bus.step;
  assign match = bus.brk_en && (bus.pc == bus.brk_addr) && !skip;
  always_comb begin
    state_n = state;
    brk_hit_n = brk_hit;
    skip_n = 1'b0;
    case (state)
      S_HALT: state_n = stop_q ? S_HALT : step_q ? S_STEP : run_q ? S_RUN : S_HALT;
      S_RUN: begin
        state_n = stop_q ? S_HALT : match ? S_BRK : S_RUN;
        brk_hit_n = !stop_q && match;
      end
      S_STEP: state_n = S_HALT;
      default: begin
        state_n = stop_q ? S_HALT : step_q ? S_STEP : run_q ? S_RUN : S_BRK;
        brk_hit_n = !(stop_q | step_q | run_q);
        skip_n = !stop_q && (step_q | run_q);
      end
    endcase
  end
  always_ff @(posedge INCLK or posedge RST) begin
    if (RST) begin
      phase <= 3'd0;
      state <= S_HALT;
      haltn <= 1'b0;
      brk_hit <= 1'b0;
      skip <= 1'b0;
      p_run <= 1'b0;
      p_stop <= 1'b0;
      p_step <= 1'b0;
      cnt <= '0;
    end else begin
      phase <= bnd ? 3'd0 : phase + 3'd1;
      p_run <= !bnd && run_q;
      p_stop <= !bnd && stop_q;
      p_step <= !bnd && step_q;
      if (bnd) begin
        state <= state_n;
        haltn <= (state_n == S_RUN) || (state_n == S_STEP);
        brk_hit <= brk_hit_n;
        skip <= skip_n;
        if (haltn && cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.haltn = haltn;
  assign bus.state = state;
  assign bus.phase = phase;
  assign bus.cyc_end = bnd & haltn;
  assign bus.brk_hit = brk_hit;
  assign bus.cyc_cnt = cnt;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed checks of boundary-aligned run/stop/step/breakpoint control and counter saturation
module tb_cycle_sequencer;
  logic INCLK = 1'b0;
  logic RST = 1'b1;
  int cmp = 0;
  int err = 0;
  cycle_sequencer_if #(.PC_W(8), .CNT_W(16)) u1 ();
  cycle_sequencer_if #(.PC_W(8), .CNT_W(4)) u2 ();
  cycle_sequencer #(.PC_W(8), .CNT_W(16)) dut (.INCLK(INCLK), .RST(RST), .bus(u1));
  cycle_sequencer #(.PC_W(8), .CNT_W(4)) dut_sat (.INCLK(INCLK), .RST(RST), .bus(u2));
  always #5 INCLK = ~INCLK;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge INCLK);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  initial begin
    {u1.run, u1.stop, u1.step, u1.brk_en} = '0;
    u1.brk_addr = 8'h1A;
    u1.pc = 8'h00;
    {u2.run, u2.stop, u2.step, u2.brk_en} = '0;
    u2.brk_addr = 8'h00;
    u2.pc = 8'h55;
    #12;
    chk("rst_phase", u1.phase, 0);
    chk("rst_state", u1.state, 0);
    chk("rst_haltn", u1.haltn, 0);
    chk("rst_brk_hit", u1.brk_hit, 0);
    chk("rst_cnt", u1.cyc_cnt, 0);
    chk("rst_cyc_end", u1.cyc_end, 0);
    #1 RST = 1'b0;
    tick(2);
    chk("phase2", u1.phase, 2);
    u1.run = 1'b1;
    tick(1);
    u1.run = 1'b0;
    chk("run_pending_haltn", u1.haltn, 0);
    tick(2);
    chk("run_ph5_haltn", u1.haltn, 0);
    chk("run_ph5_cyc_end", u1.cyc_end, 0);
    tick(1);
    chk("run_rise_haltn", u1.haltn, 1);
    chk("run_rise_state", u1.state, 1);
    chk("run_rise_phase", u1.phase, 0);
    tick(5);
    chk("run_cyc_end", u1.cyc_end, 1);
    tick(55);
    chk("run_cnt10", u1.cyc_cnt, 10);
    tick(1);
    u1.stop = 1'b1;
    tick(1);
    u1.stop = 1'b0;
    chk("stop_ph2_haltn", u1.haltn, 1);
    tick(3);
    chk("stop_ph5_haltn", u1.haltn, 1);
    tick(1);
    chk("stop_haltn", u1.haltn, 0);
    chk("stop_state", u1.state, 0);
    chk("stop_cnt", u1.cyc_cnt, 11);
    u1.stop = 1'b1;
    u1.step = 1'b1;
    tick(6);
    u1.stop = 1'b0;
    u1.step = 1'b0;
    chk("stopstep_state", u1.state, 0);
    chk("stopstep_haltn", u1.haltn, 0);
    u1.step = 1'b1;
    tick(6);
    chk("step1_haltn", u1.haltn, 1);
    chk("step1_state", u1.state, 2);
    tick(5);
    chk("step1_cyc_end", u1.cyc_end, 1);
    tick(1);
    chk("step1_end_haltn", u1.haltn, 0);
    chk("step1_end_state", u1.state, 0);
    chk("step1_cnt", u1.cyc_cnt, 12);
    tick(5);
    chk("step_gap_haltn", u1.haltn, 0);
    tick(1);
    chk("step2_haltn", u1.haltn, 1);
    chk("step2_state", u1.state, 2);
    tick(2);
    u1.step = 1'b0;
    tick(4);
    chk("step2_end_haltn", u1.haltn, 0);
    chk("step2_cnt", u1.cyc_cnt, 13);
    tick(6);
    chk("step_idle_state", u1.state, 0);
    chk("step_idle_haltn", u1.haltn, 0);
    chk("step_idle_cnt", u1.cyc_cnt, 13);
    u1.brk_en = 1'b1;
    u1.run = 1'b1;
    tick(1);
    u1.run = 1'b0;
    tick(5);
    chk("brk_run_state", u1.state, 1);
    tick(5);
    u1.pc = 8'h1A;
    tick(1);
    chk("brk_state", u1.state, 3);
    chk("brk_hit", u1.brk_hit, 1);
    chk("brk_haltn", u1.haltn, 0);
    chk("brk_cnt", u1.cyc_cnt, 14);
    u1.run = 1'b1;
    tick(1);
    u1.run = 1'b0;
    tick(5);
    chk("resume_state", u1.state, 1);
    chk("resume_brk_hit", u1.brk_hit, 0);
    chk("resume_haltn", u1.haltn, 1);
    tick(6);
    chk("skip_state", u1.state, 1);
    chk("skip_brk_hit", u1.brk_hit, 0);
    chk("skip_cnt", u1.cyc_cnt, 15);
    tick(6);
    chk("rebrk_state", u1.state, 3);
    chk("rebrk_hit", u1.brk_hit, 1);
    chk("rebrk_cnt", u1.cyc_cnt, 16);
    u1.stop = 1'b1;
    tick(6);
    u1.stop = 1'b0;
    chk("brkstop_state", u1.state, 0);
    chk("brkstop_hit", u1.brk_hit, 0);
    u1.brk_en = 1'b0;
    u1.pc = 8'h00;
    u1.run = 1'b1;
    tick(6);
    u1.run = 1'b0;
    tick(3);
    chk("pre_rst_phase", u1.phase, 3);
    chk("pre_rst_haltn", u1.haltn, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_haltn", u1.haltn, 0);
    chk("arst_phase", u1.phase, 0);
    chk("arst_cnt", u1.cyc_cnt, 0);
    chk("arst_state", u1.state, 0);
    #1 RST = 1'b0;
    u2.run = 1'b1;
    tick(6);
    chk("sat_run_haltn", u2.haltn, 1);
    tick(90);
    chk("sat_cnt15", u2.cyc_cnt, 15);
    tick(30);
    chk("sat_hold", u2.cyc_cnt, 15);
    chk("sat_main_idle", u1.cyc_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
